ps2_kbd_decoder: RTL and testbench
==================================

# ps2_kbd_decoder

Scan-code set 2 decoder sitting directly downstream of the PS/2 controller FSM. It consumes received bytes and status flags, folds the E0/F0/E1 prefix sequences into single key events, and buffers them in a small FIFO with a valid/ready output handshake. It also owns the controller's `en` input, pulsing it low to re-arm the controller after any error.

## Interface
- `DEPTH`, default 4: event FIFO depth; power of two, ≥ 2.
- `CNT_W`, default 8: width of the error counter.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `enable` in 1: software enable for keyboard reception.
- `tx_active` in 1: host transmit in progress. While high, `rx_valid` is ignored.
- `rx_valid` in 1: controller `valid`.
- `rx_data` in 8: controller received byte; stable while `rx_valid` is high.
- `rx_flags` in `ps2_pkg::flags_t`: controller flags (`parity_error`, `frame_error`, `clk_timeout`, `rqst_timeout`).
- `ps2_en` out 1: drives controller `en`.
- `ev_valid` out 1: FIFO head holds an event.
- `ev_ready` in 1: consumer accepts the head event.
- `ev_code` out 8: key code. Prefix stripped; E1 for pause.
- `ev_ext` out 1: E0-prefixed key.
- `ev_brk` out 1: release (F0 seen).
- `ev_pause` out 1: complete pause sequence.
- `ev_sys` out 1: keyboard response byte, not a key.
- `ovf` out 1: sticky FIFO overflow.
- `ovf_clr` in 1: clears `ovf`.
- `err_cnt` out `CNT_W`: saturating count of flagged receptions.

## Operation
- **Byte acceptance.** A byte is accepted when `acc = rx_valid & !tx_active & ps2_en`, evaluated once per clock.
- **Error path.**
  - If `acc` and any `rx_flags` bit is set, the block enters RECOVER regardless of state.
  - It increments `err_cnt`, saturating at all-ones, and discards any partial prefix.
- **Controller enable.** `ps2_en = enable & (state != RECOVER)`.
  - RECOVER lasts exactly 2 cycles, then the block goes to IDLE.
  - This forces the controller through INHIBIT, which clears its held error `valid`.
- **Decode FSM.** States: IDLE, E0, F0, E0F0, PAUSE, RECOVER. Transitions on a flag-free `acc` byte b:
  - IDLE:
    - b=E0 → E0.
    - b=F0 → F0.
    - b=E1 → PAUSE, `pcnt` := 7.
    - b ∈ {AA, FA, FE, EE, FC, 00, FF} → push `{b, sys=1}`, stay in IDLE.
    - Otherwise → push `{b}`, stay in IDLE.
  - E0:
    - b=F0 → E0F0.
    - b=E0 → E0 (repeated prefix tolerated).
    - Otherwise → push `{b, ext=1}`, go to IDLE.
  - F0: push `{b, brk=1}`, go to IDLE.
  - E0F0: push `{b, ext=1, brk=1}`, go to IDLE.
  - PAUSE: decrement `pcnt`. When `pcnt` was 1, push `{E1, pause=1}` and go to IDLE. Byte content is not checked.
- **Enable drop.** `enable` low in any state → IDLE next cycle. `pcnt` cleared, FIFO preserved.
- **FIFO.**
  - `DEPTH` entries; pointers are `$clog2(DEPTH)+1` bits wide, wrapping naturally.
  - Full when MSBs differ and the low bits are equal. Empty when the pointers are equal.
  - Pop when `ev_valid & ev_ready`.
  - Push while full, without a same-cycle pop: event dropped, `ovf` set.
  - Push and pop in the same cycle while full: both happen, `ovf` unchanged.
  - Push and pop in the same cycle while empty: push only, since `ev_valid` was 0.
- **`ovf` update.** `ovf_clr` and a new overflow in the same cycle → `ovf` stays 1.

## Timing
- Reset values:
  - state = IDLE, `pcnt` = 0, FIFO empty.
  - `ev_valid` = 0 and all `ev_*` = 0.
  - `ovf` = 0, `err_cnt` = 0.
  - `ps2_en` = `enable` (combinational).
- Latency: an accepted final byte at edge N makes `ev_valid` = 1 after edge N, i.e. 1 cycle.
- Head outputs come straight from the FIFO storage. They are stable while `ev_valid & !ev_ready`.
- The controller's RX_DONE `valid` lasts 1 cycle, so each byte is accepted exactly once. No edge detection is needed.
- An error `valid` stays high until `ps2_en` drops. `err_cnt` increments once per error because RECOVER blocks `acc`.
- `ps2_en` is low for exactly the 2 RECOVER cycles and returns high on the 3rd if `enable` is high.
- `rst_n` asserted mid-sequence clears everything asynchronously. There are no partial events after release.

## Test plan
- **Plain make/break.** Bytes 1C, F0, 1C → events {1C,ext0,brk0}, {1C,ext0,brk1}. `ev_valid` rises 1 cycle after each final byte.
- **Extended release.** Bytes E0, F0, 75 → single event {75,ext1,brk1}. No event on E0 or F0.
- **Pause.** Bytes E1 14 77 E1 F0 14 F0 77 → exactly one event {E1,pause=1}, emitted after the 8th byte. A following 1C decodes normally.
- **Parity error mid-sequence.** Bytes E0, then `valid` held high with `parity_error` → `ps2_en` low for 2 cycles, `err_cnt`=1, no event emitted. The next 1C decodes as {1C,ext0}.
- **Overflow.** `ev_ready`=0, `DEPTH`=4, 5 single-byte codes 01..05 → FIFO holds 01..04, `ovf`=1. Drain order is 01,02,03,04, and `ovf_clr` returns it to 0.
- **Full push+pop and gating.** FIFO full with `ev_ready`=1 while byte 06 arrives → count stays 4, 06 lands last, `ovf` stays 0. With `tx_active`=1, `rx_valid` pulses produce no events.

Source files
------------

// File: rtl/ps2_kbd_decoder.sv
// PS/2 scan-code set 2 decoder: folds E0/F0/E1 prefixes into single key events,
// buffers them in a small FIFO and re-arms the controller after reception errors.

package ps2_pkg;
  typedef struct packed {
    logic parity_error;
    logic frame_error;
    logic clk_timeout;
    logic rqst_timeout;
  } flags_t;
endpackage

module ps2_kbd_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             tx_active,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  ps2_pkg::flags_t  rx_flags,
  output logic             ps2_en,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_brk,
  output logic             ev_pause,
  output logic             ev_sys,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int EVT_W = 12;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_E0      = 3'd1;
  localparam logic [2:0] ST_F0      = 3'd2;
  localparam logic [2:0] ST_E0F0    = 3'd3;
  localparam logic [2:0] ST_PAUSE   = 3'd4;
  localparam logic [2:0] ST_RECOVER = 3'd5;

  // Event record layout: {code[7:0], ext, brk, pause, sys}
  function automatic logic [EVT_W-1:0] make_evt(input logic [7:0] code, input logic ext,
                                                input logic brk, input logic pause,
                                                input logic sys);
    make_evt = {code, ext, brk, pause, sys};
  endfunction

  function automatic logic is_sys_byte(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hFC, 8'h00, 8'hFF: is_sys_byte = 1'b1;
      default:                                         is_sys_byte = 1'b0;
    endcase
  endfunction

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [2:0]       pcnt_r;
  logic [2:0]       pcnt_nxt_s;
  logic             rcnt_r;
  logic             rcnt_nxt_s;
  logic             acc_s;
  logic             err_s;
  logic             push_s;
  logic [EVT_W-1:0] push_evt_s;

  logic [EVT_W-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             full_s;
  logic             empty_s;
  logic             pop_s;
  logic             wr_en_s;
  logic             ovf_set_s;
  logic [EVT_W-1:0] head_s;
  logic             ovf_r;
  logic [CNT_W-1:0] err_cnt_r;

  // RECOVER deasserts the controller enable, which forces it through INHIBIT.
  assign ps2_en = enable & (state_r != ST_RECOVER);
  assign acc_s  = rx_valid & ~tx_active & ps2_en;
  assign err_s  = acc_s & (|rx_flags);

  // Decode next-state and event generation.
  always_comb begin
    state_nxt_s = state_r;
    pcnt_nxt_s  = pcnt_r;
    rcnt_nxt_s  = rcnt_r;
    push_s      = 1'b0;
    push_evt_s  = {EVT_W{1'b0}};
    if (!enable) begin
      state_nxt_s = ST_IDLE;
      pcnt_nxt_s  = 3'd0;
      rcnt_nxt_s  = 1'b0;
    end else if (state_r == ST_RECOVER) begin
      if (rcnt_r) begin
        state_nxt_s = ST_IDLE;
        rcnt_nxt_s  = 1'b0;
      end else begin
        rcnt_nxt_s  = 1'b1;
      end
    end else if (err_s) begin
      state_nxt_s = ST_RECOVER;
      pcnt_nxt_s  = 3'd0;
      rcnt_nxt_s  = 1'b0;
    end else if (acc_s) begin
      case (state_r)
        ST_IDLE: begin
          if (rx_data == 8'hE0) begin
            state_nxt_s = ST_E0;
          end else if (rx_data == 8'hF0) begin
            state_nxt_s = ST_F0;
          end else if (rx_data == 8'hE1) begin
            state_nxt_s = ST_PAUSE;
            pcnt_nxt_s  = 3'd7;
          end else begin
            push_s     = 1'b1;
            push_evt_s = make_evt(rx_data, 1'b0, 1'b0, 1'b0, is_sys_byte(rx_data));
          end
        end
        ST_E0: begin
          if (rx_data == 8'hF0) begin
            state_nxt_s = ST_E0F0;
          end else if (rx_data == 8'hE0) begin
            state_nxt_s = ST_E0;
          end else begin
            state_nxt_s = ST_IDLE;
            push_s      = 1'b1;
            push_evt_s  = make_evt(rx_data, 1'b1, 1'b0, 1'b0, 1'b0);
          end
        end
        ST_F0: begin
          state_nxt_s = ST_IDLE;
          push_s      = 1'b1;
          push_evt_s  = make_evt(rx_data, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        ST_E0F0: begin
          state_nxt_s = ST_IDLE;
          push_s      = 1'b1;
          push_evt_s  = make_evt(rx_data, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        ST_PAUSE: begin
          // Pause bytes are counted, not checked; the last one emits the event.
          if (pcnt_r <= 3'd1) begin
            state_nxt_s = ST_IDLE;
            pcnt_nxt_s  = 3'd0;
            push_s      = 1'b1;
            push_evt_s  = make_evt(8'hE1, 1'b0, 1'b0, 1'b1, 1'b0);
          end else begin
            pcnt_nxt_s  = pcnt_r - 3'd1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          pcnt_nxt_s  = 3'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Decoder state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pcnt_r  <= 3'd0;
      rcnt_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pcnt_r  <= pcnt_nxt_s;
      rcnt_r  <= rcnt_nxt_s;
    end
  end

  // Saturating count of flagged receptions; RECOVER keeps it to one per error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (err_s && (err_cnt_r != {CNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s     = ev_valid & ev_ready;
  // A push into a full FIFO only lands if the head leaves in the same cycle.
  assign wr_en_s   = push_s & (~full_s | pop_s);
  assign ovf_set_s = push_s & full_s & ~pop_s;

  // Event storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {EVT_W{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_evt_s;
    end else begin
      mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Sticky overflow; a fresh overflow wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign head_s   = mem_r[rd_ptr_r[AW-1:0]];
  assign ev_valid = ~empty_s;
  assign ev_code  = head_s[11:4];
  assign ev_ext   = head_s[3];
  assign ev_brk   = head_s[2];
  assign ev_pause = head_s[1];
  assign ev_sys   = head_s[0];
  assign ovf      = ovf_r;
  assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder: a byte/expected-event table plus
// hand-written sequences for error recovery, overflow, gating and reset.

module tb_ps2_kbd_decoder;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable;
  logic            tx_active;
  logic            rx_valid;
  logic [7:0]      rx_data;
  ps2_pkg::flags_t rx_flags;
  logic            ps2_en;
  logic            ev_valid;
  logic            ev_ready;
  logic [7:0]      ev_code;
  logic            ev_ext;
  logic            ev_brk;
  logic            ev_pause;
  logic            ev_sys;
  logic            ovf;
  logic            ovf_clr;
  logic [7:0]      err_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  data;
    logic        exp_v;
    logic [11:0] exp_evt;
  } vec_t;

  vec_t vecs[$];

  ps2_kbd_decoder #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .tx_active(tx_active),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_flags(rx_flags), .ps2_en(ps2_en),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_brk(ev_brk), .ev_pause(ev_pause), .ev_sys(ev_sys), .ovf(ovf),
    .ovf_clr(ovf_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] head();
    return {ev_code, ev_ext, ev_brk, ev_pause, ev_sys};
  endfunction

  // evt layout {code, ext, brk, pause, sys}
  task automatic add(input logic [7:0] d, input logic v, input logic [11:0] e);
    vec_t t;
    t.data = d; t.exp_v = v; t.exp_evt = e;
    vecs.push_back(t);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pop();
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; tx_active = 1'b0; rx_valid = 1'b0;
    rx_data = 8'h00; rx_flags = 4'b0000; ev_ready = 1'b0; ovf_clr = 1'b0;

    add(8'h1C, 1'b1, {8'h1C, 4'b0000});
    add(8'hF0, 1'b0, 12'h000);
    add(8'h1C, 1'b1, {8'h1C, 4'b0100});
    add(8'hE0, 1'b0, 12'h000);
    add(8'hF0, 1'b0, 12'h000);
    add(8'h75, 1'b1, {8'h75, 4'b1100});
    add(8'hE0, 1'b0, 12'h000);
    add(8'h70, 1'b1, {8'h70, 4'b1000});
    add(8'hE0, 1'b0, 12'h000);
    add(8'hE0, 1'b0, 12'h000);
    add(8'h6B, 1'b1, {8'h6B, 4'b1000});
    add(8'hE1, 1'b0, 12'h000);
    add(8'h14, 1'b0, 12'h000);
    add(8'h77, 1'b0, 12'h000);
    add(8'hE1, 1'b0, 12'h000);
    add(8'hF0, 1'b0, 12'h000);
    add(8'h14, 1'b0, 12'h000);
    add(8'hF0, 1'b0, 12'h000);
    add(8'h77, 1'b1, {8'hE1, 4'b0010});
    add(8'h1C, 1'b1, {8'h1C, 4'b0000});
    add(8'hFA, 1'b1, {8'hFA, 4'b0001});
    add(8'hAA, 1'b1, {8'hAA, 4'b0001});
    add(8'hF0, 1'b0, 12'h000);
    add(8'hAA, 1'b1, {8'hAA, 4'b0100});

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ev_valid", ev_valid, 1'b0);
    check("rst_head", head(), 12'h000);
    check("rst_ovf", ovf, 1'b0);
    check("rst_err_cnt", err_cnt, 8'd0);
    check("rst_ps2_en", ps2_en, 1'b1);
    rst_n = 1'b1;

    // Table-driven decode
    foreach (vecs[i]) begin
      send_byte(vecs[i].data);
      check($sformatf("vec%0d_valid", i), ev_valid, vecs[i].exp_v);
      if (vecs[i].exp_v) begin
        check($sformatf("vec%0d_evt", i), head(), vecs[i].exp_evt);
        pop();
        check($sformatf("vec%0d_drained", i), ev_valid, 1'b0);
      end
    end

    // Parity error mid-sequence: valid held high until ps2_en drops
    send_byte(8'hE0);
    rx_data = 8'h5A; rx_valid = 1'b1; rx_flags.parity_error = 1'b1;
    @(negedge clk);
    check("rec_en_c1", ps2_en, 1'b0);
    check("rec_err_cnt", err_cnt, 8'd1);
    @(negedge clk);
    check("rec_en_c2", ps2_en, 1'b0);
    rx_valid = 1'b0; rx_flags = 4'b0000;
    @(negedge clk);
    check("rec_en_back", ps2_en, 1'b1);
    check("rec_err_cnt_once", err_cnt, 8'd1);
    check("rec_no_event", ev_valid, 1'b0);
    send_byte(8'h1C);
    check("rec_next_evt", head(), {8'h1C, 4'b0000});
    pop();

    // Enable drop discards a partial prefix
    send_byte(8'hE0);
    enable = 1'b0;
    #1 check("endrop_ps2_en", ps2_en, 1'b0);
    @(negedge clk);
    enable = 1'b1;
    send_byte(8'h1C);
    check("endrop_evt", head(), {8'h1C, 4'b0000});
    pop();

    // Host transmit gates reception
    tx_active = 1'b1;
    for (int k = 0; k < 3; k++) send_byte(8'h1C);
    check("tx_gate", ev_valid, 1'b0);
    tx_active = 1'b0;

    // Overflow with ev_ready low
    for (int k = 1; k <= 5; k++) send_byte(k[7:0]);
    check("ovf_set", ovf, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovf_drain%0d", k), ev_code, k[31:0]);
      pop();
    end
    check("ovf_empty", ev_valid, 1'b0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", ovf, 1'b0);

    // Full FIFO: push and pop in the same cycle
    for (int k = 1; k <= 4; k++) send_byte(k[7:0]);
    rx_data = 8'h06; rx_valid = 1'b1; ev_ready = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; ev_ready = 1'b0;
    check("fpp_ovf", ovf, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fpp_drain%0d", k), ev_code, (k == 3) ? 32'h06 : k + 2);
      pop();
    end
    check("fpp_count4", ev_valid, 1'b0);

    // Asynchronous reset mid-sequence
    send_byte(8'h1C);
    send_byte(8'hE0);
    #2 rst_n = 1'b0;
    #1 check("arst_ev_valid", ev_valid, 1'b0);
    check("arst_err_cnt", err_cnt, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h75);
    check("arst_no_prefix", head(), {8'h75, 4'b0000});
    pop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
